// File: rtl/if_fetch_buf.sv
// if_fetch_buf -- instruction fetch stage with decoupled SRAM-like port.
//
// Keeps up to MAX_OUTSTANDING fetches in flight on the addr_ok/data_ok
// instruction port. It buffers returned words in an IBUF_DEPTH-entry FIFO
// that feeds ID. Redirects cancel in-flight fetches, and a misaligned fetch
// PC produces a single ADEF entry, after which fetch stops until the next
// redirect.
//
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   inst_sram_*               request/response instruction port
//   id_allowin                ID accepts the head entry this cycle
//   br_taken_id/_exe, ertn_flush, exec_flush (+ targets)   redirects
//   if_to_id_valid, if_inst, if_pc, if_exc_adef            buffer head to ID
module if_fetch_buf #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_allowin,
    input  logic        br_taken_id,
    input  logic [31:0] br_target_id,
    input  logic        br_taken_exe,
    input  logic [31:0] br_target_exe,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    input  logic        exec_flush,
    input  logic [31:0] exec_pc,
    output logic        if_to_id_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_exc_adef
);
    localparam int CW  = $clog2(IBUF_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int AW  = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ibuf_entry_t;

    logic [31:0]   pc_req;
    logic [CW-1:0] outstanding, cancel_cnt, fifo_count;
    logic [31:0]   pc_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] pcf_wr, pcf_rd;
    ibuf_entry_t   ibuf [IBUF_DEPTH];
    logic [AW-1:0] ib_wr, ib_rd;
    logic          adef_done, redir_v, req_hold, started;
    logic [31:0]   redir_pc;

    function automatic logic [PW-1:0] pcf_next(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Redirect select: exception > ertn > EXE branch > ID branch.
    logic        redirect;
    logic [31:0] redir_tgt;
    always_comb begin
        redirect = exec_flush | ertn_flush | br_taken_exe | br_taken_id;
        if (exec_flush)        redir_tgt = exec_pc;
        else if (ertn_flush)   redir_tgt = ertn_pc;
        else if (br_taken_exe) redir_tgt = br_target_exe;
        else                   redir_tgt = br_target_id;
    end

    // live = in-flight fetches whose data will land in the buffer; buffer
    // entries plus live ones never exceed IBUF_DEPTH, so a beat always fits.
    logic [CW-1:0] live, outstanding_nxt;
    logic [CW:0]   credit;
    logic          issue_ok, accept, resp, resp_keep, adef_push, push, pop;
    ibuf_entry_t   push_entry;

    assign live     = outstanding - cancel_cnt;
    assign credit   = {1'b0, fifo_count} + {1'b0, live};
    assign issue_ok = started && (pc_req[1:0] == 2'b00) && !adef_done && !redir_v
                   && (outstanding < CW'(MAX_OUTSTANDING))
                   && (credit < CW1'(IBUF_DEPTH));

    // req_hold keeps an unaccepted request stable whatever else happens.
    assign inst_sram_req   = req_hold | issue_ok;
    assign inst_sram_addr  = pc_req;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wdata = 32'd0;

    assign accept          = inst_sram_req & inst_sram_addr_ok;
    assign resp            = inst_sram_data_ok && (outstanding != '0);
    assign resp_keep       = resp && (cancel_cnt == '0);
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(resp);
    assign adef_push = started && (pc_req[1:0] != 2'b00) && !adef_done && !redir_v
                    && (live == '0) && (fifo_count < CW'(IBUF_DEPTH)) && !redirect;
    assign push      = (resp_keep & !redirect) | adef_push;
    assign pop       = (fifo_count != '0) && id_allowin;

    always_comb begin
        push_entry = '{pc: pc_req, inst: 32'd0, adef: 1'b1};
        if (resp_keep) push_entry = '{pc: pc_fifo[pcf_rd], inst: inst_sram_rdata, adef: 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_req      <= RESET_PC;
            outstanding <= '0;
            cancel_cnt  <= '0;
            fifo_count  <= '0;
            pcf_wr      <= '0;
            pcf_rd      <= '0;
            ib_wr       <= '0;
            ib_rd       <= '0;
            adef_done   <= 1'b0;
            redir_v     <= 1'b0;
            redir_pc    <= '0;
            req_hold    <= 1'b0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            req_hold    <= inst_sram_req & ~inst_sram_addr_ok;
            outstanding <= outstanding_nxt;
            if (accept) pcf_wr <= pcf_next(pcf_wr);
            if (resp)   pcf_rd <= pcf_next(pcf_rd);

            if (redirect) begin
                // Everything still in flight after this edge is stale.
                cancel_cnt <= outstanding_nxt;
                adef_done  <= 1'b0;
                fifo_count <= '0;
                ib_wr      <= '0;
                ib_rd      <= '0;
                if (inst_sram_req && !inst_sram_addr_ok) begin
                    redir_v  <= 1'b1;
                    redir_pc <= redir_tgt;
                end else begin
                    redir_v <= 1'b0;
                    pc_req  <= redir_tgt;
                end
            end else begin
                // A held request accepted after a redirect is itself stale.
                cancel_cnt <= cancel_cnt - CW'(resp && (cancel_cnt != '0))
                                         + CW'(accept && redir_v);
                if (accept && redir_v) begin
                    pc_req  <= redir_pc;
                    redir_v <= 1'b0;
                end else if (accept) begin
                    pc_req <= pc_req + 32'd4;
                end
                if (adef_push) adef_done <= 1'b1;
                if (push) ib_wr <= ib_wr + AW'(1);
                if (pop)  ib_rd <= ib_rd + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays need no reset; pointers and counts qualify them.
    always_ff @(posedge clk) begin
        if (accept) pc_fifo[pcf_wr] <= pc_req;
        if (push)   ibuf[ib_wr]     <= push_entry;
    end

    assign if_to_id_valid = (fifo_count != '0);
    assign if_inst        = if_to_id_valid ? ibuf[ib_rd].inst : 32'd0;
    assign if_pc          = if_to_id_valid ? ibuf[ib_rd].pc   : 32'd0;
    assign if_exc_adef    = if_to_id_valid & ibuf[ib_rd].adef;
endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: a small zero-wait memory model answers
// each accepted fetch with ~addr one cycle later, and every entry ID takes
// is logged and compared against the expected PC stream.
module tb_if_fetch_buf;
    logic        clk;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        id_allowin;
    logic        br_taken_id, br_taken_exe, ertn_flush, exec_flush;
    logic [31:0] br_target_id, br_target_exe, ertn_pc, exec_pc;
    logic        if_to_id_valid, if_exc_adef;
    logic [31:0] if_inst, if_pc;

    if_fetch_buf dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .id_allowin(id_allowin),
        .br_taken_id(br_taken_id), .br_target_id(br_target_id),
        .br_taken_exe(br_taken_exe), .br_target_exe(br_target_exe),
        .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
        .exec_flush(exec_flush), .exec_pc(exec_pc),
        .if_to_id_valid(if_to_id_valid), .if_inst(if_inst),
        .if_pc(if_pc), .if_exc_adef(if_exc_adef)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_pass = 0, n_fail = 0, n_total = 0;
    int          n_acc = 0, n_cons = 0, req_hi, valid_hi;
    logic        resp_en;
    logic [31:0] mem_q[$];
    logic [31:0] got_pc[$], got_inst[$];
    logic        got_adef[$];
    logic [31:0] exp_pc, hold_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_resp();
        inst_sram_data_ok = resp_en && (mem_q.size() > 0);
        inst_sram_rdata   = inst_sram_data_ok ? ~mem_q[0] : 32'd0;
    endtask

    // One clock: sample handshakes mid-cycle, then advance the memory model.
    task automatic cyc();
        logic        acc, dok;
        logic [31:0] a;
        @(negedge clk);
        acc = inst_sram_req & inst_sram_addr_ok;
        a   = inst_sram_addr;
        dok = inst_sram_data_ok;
        if (if_to_id_valid && id_allowin) begin
            got_pc.push_back(if_pc);
            got_inst.push_back(if_inst);
            got_adef.push_back(if_exc_adef);
            n_cons++;
        end
        @(posedge clk);
        #1;
        if (dok) void'(mem_q.pop_front());
        if (acc) begin
            mem_q.push_back(a);
            n_acc++;
        end
        drive_resp();
    endtask

    task automatic clear_log();
        got_pc.delete();
        got_inst.delete();
        got_adef.delete();
    endtask

    task automatic check_log(input string tag, input int lo, input int hi);
        if (lo == hi) chk({tag, " count"}, 32'(got_pc.size()), 32'(lo));
        else chk({tag, " count in range"}, 32'(got_pc.size() >= lo && got_pc.size() <= hi), 32'd1);
        for (int i = 0; i < got_pc.size(); i++) begin
            chk({tag, " pc"}, got_pc[i], exp_pc);
            chk({tag, " inst"}, got_inst[i], ~exp_pc);
            chk({tag, " adef"}, 32'(got_adef[i]), 32'd0);
            exp_pc = exp_pc + 32'd4;
        end
        clear_log();
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'd0;
        id_allowin = 1'b1;
        br_taken_id = 1'b0;  br_target_id = 32'd0;
        br_taken_exe = 1'b0; br_target_exe = 32'd0;
        ertn_flush = 1'b0;   ertn_pc = 32'd0;
        exec_flush = 1'b0;   exec_pc = 32'd0;
        resp_en = 1'b1;
        repeat (3) cyc();

        // reset state
        chk("rst req", 32'(inst_sram_req), 32'd0);
        chk("rst valid", 32'(if_to_id_valid), 32'd0);
        chk("rst if_pc", if_pc, 32'd0);
        chk("rst if_inst", if_inst, 32'd0);
        chk("rst adef", 32'(if_exc_adef), 32'd0);
        chk("const size/wr", {29'd0, inst_sram_size, inst_sram_wr}, 32'd4);

        // zero-wait streaming: first request cycle 1, first valid cycle 3
        resetn = 1'b1;
        chk("pre-start req", 32'(inst_sram_req), 32'd0);
        cyc();
        chk("c1 req", 32'(inst_sram_req), 32'd1);
        chk("c1 addr", inst_sram_addr, 32'h1c000000);
        cyc();
        chk("c2 valid", 32'(if_to_id_valid), 32'd0);
        cyc();
        chk("c3 valid", 32'(if_to_id_valid), 32'd1);
        chk("c3 if_pc", if_pc, 32'h1c000000);
        chk("c3 if_inst", if_inst, ~32'h1c000000);
        exp_pc = 32'h1c000000;
        repeat (8) cyc();
        check_log("stream", 8, 8);

        // ID stalls: buffer fills to 4, fetch stops, then drains in order
        id_allowin = 1'b0;
        repeat (10) cyc();
        chk("stall valid", 32'(if_to_id_valid), 32'd1);
        chk("stall req", 32'(inst_sram_req), 32'd0);
        chk("stall head pc", if_pc, exp_pc);
        chk("stall held entries", 32'(n_acc - n_cons), 32'd4);
        chk("stall in flight", 32'(mem_q.size()), 32'd0);
        id_allowin = 1'b1;
        repeat (12) cyc();
        check_log("drain", 12, 12);

        // two stale fetches outstanding, EXE redirect
        resp_en = 1'b0;
        drive_resp();
        repeat (5) cyc();
        chk("t3 valid before", 32'(if_to_id_valid), 32'd0);
        chk("t3 req blocked", 32'(inst_sram_req), 32'd0);
        chk("t3 in flight", 32'(mem_q.size()), 32'd2);
        check_log("t3 pre", 1, 4);
        br_taken_exe = 1'b1;
        br_target_exe = 32'h1c000100;
        resp_en = 1'b1;
        drive_resp();
        cyc();
        br_taken_exe = 1'b0;
        chk("t3 valid after", 32'(if_to_id_valid), 32'd0);
        chk("t3 new req", 32'(inst_sram_req), 32'd1);
        chk("t3 new addr", inst_sram_addr, 32'h1c000100);
        clear_log();
        exp_pc = 32'h1c000100;
        repeat (10) cyc();
        check_log("t3 post", 5, 10);

        // held request across an ID redirect
        inst_sram_addr_ok = 1'b0;
        hold_a = inst_sram_addr;
        chk("t4 req", 32'(inst_sram_req), 32'd1);
        cyc();
        chk("t4 addr hold1", inst_sram_addr, hold_a);
        br_taken_id = 1'b1;
        br_target_id = 32'h1c000200;
        cyc();
        br_taken_id = 1'b0;
        chk("t4 req hold2", 32'(inst_sram_req), 32'd1);
        chk("t4 addr hold2", inst_sram_addr, hold_a);
        chk("t4 valid", 32'(if_to_id_valid), 32'd0);
        clear_log();
        cyc();
        chk("t4 addr hold3", inst_sram_addr, hold_a);
        inst_sram_addr_ok = 1'b1;
        cyc();
        chk("t4 new req", 32'(inst_sram_req), 32'd1);
        chk("t4 new addr", inst_sram_addr, 32'h1c000200);
        clear_log();
        exp_pc = 32'h1c000200;
        repeat (10) cyc();
        check_log("t4 post", 5, 10);

        // exception flush outranks a same-cycle ID branch
        exec_flush = 1'b1;  exec_pc = 32'h1c008000;
        br_taken_id = 1'b1; br_target_id = 32'h1c000300;
        cyc();
        exec_flush = 1'b0;
        br_taken_id = 1'b0;
        chk("t5 valid", 32'(if_to_id_valid), 32'd0);
        chk("t5 req", 32'(inst_sram_req), 32'd1);
        chk("t5 addr", inst_sram_addr, 32'h1c008000);
        clear_log();
        exp_pc = 32'h1c008000;
        repeat (10) cyc();
        check_log("t5 post", 5, 10);

        // ertn to a misaligned PC: one ADEF entry, then idle
        ertn_flush = 1'b1;
        ertn_pc = 32'h1c000002;
        cyc();
        ertn_flush = 1'b0;
        chk("t6 valid", 32'(if_to_id_valid), 32'd0);
        chk("t6 req", 32'(inst_sram_req), 32'd0);
        clear_log();
        cyc();
        chk("t6 adef valid", 32'(if_to_id_valid), 32'd1);
        chk("t6 adef pc", if_pc, 32'h1c000002);
        chk("t6 adef inst", if_inst, 32'd0);
        chk("t6 adef flag", 32'(if_exc_adef), 32'd1);
        chk("t6 adef req", 32'(inst_sram_req), 32'd0);
        req_hi = 0;
        valid_hi = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            req_hi += int'(inst_sram_req);
            valid_hi += int'(if_to_id_valid);
        end
        chk("t6 idle req", 32'(req_hi), 32'd0);
        chk("t6 idle valid", 32'(valid_hi), 32'd0);
        chk("t6 log count", 32'(got_pc.size()), 32'd1);
        chk("t6 log pc", got_pc[0], 32'h1c000002);
        chk("t6 log inst", got_inst[0], 32'd0);
        chk("t6 log adef", 32'(got_adef[0]), 32'd1);
        clear_log();
        br_taken_id = 1'b1;
        br_target_id = 32'h1c000400;
        cyc();
        br_taken_id = 1'b0;
        chk("t6 resume req", 32'(inst_sram_req), 32'd1);
        chk("t6 resume addr", inst_sram_addr, 32'h1c000400);
        repeat (4) cyc();

        // reset mid-stream discards everything
        resetn = 1'b0;
        cyc();
        mem_q.delete();
        drive_resp();
        chk("mid rst req", 32'(inst_sram_req), 32'd0);
        chk("mid rst valid", 32'(if_to_id_valid), 32'd0);
        chk("mid rst if_pc", if_pc, 32'd0);
        resetn = 1'b1;
        cyc();
        chk("mid rst restart req", 32'(inst_sram_req), 32'd1);
        chk("mid rst restart addr", inst_sram_addr, 32'h1c000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
